serial_subtractor: RTL

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Built around a single full-subtractor cell and a one-bit borrow register.
- Companion block to the combinational adder cells in the lab datapath; trades latency for one-cell area.
- Sits behind a start/done handshake so a controller or testbench can sequence operations.

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional two's-complement overflow output: SERIAL_SUB_OVERFLOW_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; the serial datapath reuses it every cycle.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_x;

    assign w_x  = a ^ b;
    assign d    = w_x ^ bin;
    assign bout = (~a & b) | (~w_x & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, behind a start/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered ovf output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_ps;
    logic               r_bin;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_cat;

    full_subtractor u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    // New bit enters at the top; after the last bit this is the full result.
    assign w_cat  = {w_d, r_ps};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_ps     <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_sa  <= a;
                r_sb  <= b;
                r_ps  <= '0;
                r_bin <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                r_ps  <= w_cat[WIDTH-1:1];
                r_bin <= w_bout;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_diff   <= w_cat;
                    r_borrow <= w_bout;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end else if (r_state == RUN && w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
